systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Double-ported operand staging buffer that sits directly upstream of the MAC array manager. It holds one N×N A tile and one N×N B tile. On command, it streams them as diagonally skewed vectors, one per cycle, on the array's A-column and B-row inputs, so that A[i][k] and B[k][j] meet in PE(i,j). After the data it drives zero flush cycles so the array can drain, then reports completion.

## Interface
- N, 16, tile dimension (rows of A, columns of B, shared inner dimension); must be ≥ 1
- OP_WIDTH, 8, operand width in bits
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write one tile row this cycle
- wr_sel  in  1  0 = A buffer, 1 = B buffer
- wr_row  in  max(1,$clog2(N))  row index; values ≥ N are ignored
- wr_data  in  N*OP_WIDTH  row data; element c at bits [c*OP_WIDTH +: OP_WIDTH]
- start  in  1  begin streaming (one-cycle pulse or level; sampled only in IDLE)
- busy  out  1  high in STREAM and DRAIN
- done  out  1  one-cycle completion pulse
- out_valid  out  1  high while skewed tile data is on a_column/b_row
- a_column  out  N*OP_WIDTH  lane i = A-row i input of the array
- b_row  out  N*OP_WIDTH  lane j = B-column j input of the array

## Operation
- Storage: A[N][N] and B[N][N] registers. A write stores wr_data into row wr_row of the selected buffer.
- Writes are accepted only when busy=0. While busy, writes are dropped and the buffers are unchanged.
- States: IDLE, STREAM, DRAIN. The step counter t has width $clog2(3N)+1.
  - IDLE: if start=1, go to STREAM with t=0.
  - STREAM: emit step t. When t=2N-2, go to DRAIN with t=0 (or to IDLE with done=1 if N=1). Otherwise t++.
  - DRAIN: outputs zero and out_valid=0. When t=N-2, go to IDLE and assert done. Otherwise t++.
- Skew rule at step t:
  - a_column lane i = A[i][t-i] if 0 ≤ t-i < N, else 0.
  - b_row lane j = B[t-j][j] if 0 ≤ t-j < N, else 0.
- start while busy is ignored. Streaming does not auto-restart.
- A write and start in the same IDLE cycle: the write commits and is included in the stream.
- reset (any state, including mid-stream) gives:
  - state IDLE, t=0;
  - busy=0, done=0, out_valid=0;
  - a_column=0, b_row=0;
  - both buffers cleared to 0.
  - No done pulse is produced for the aborted stream.

## Timing
- All outputs are registered. Reset values: every output is 0.
- start sampled at edge E0 → step 0 visible in the cycle after E0 (busy=1, out_valid=1).
- Step t is visible in cycle t+1 after E0, for t = 0..2N-2 (2N-1 valid cycles).
- DRAIN occupies N-1 cycles with zero outputs and busy=1.
- done=1 and busy=0 in the same cycle, 3N-1 cycles after E0 (for N=1: 2 cycles after E0). done lasts exactly one cycle.
- A new start is accepted in the done cycle, i.e. back-to-back tiles with no gap.
- Writes issued in the done cycle are accepted.

## Test plan
All scenarios use N=2, OP_WIDTH=8.
- Basic skew:
  - Stimulus: write A rows {0:0x0201, 1:0x0403} (A=[[1,2],[3,4]]) and B rows {0:0x0605, 1:0x0807} (B=[[5,6],[7,8]]), then pulse start.
  - Required response: a_column/b_row = 0x0001/0x0005, then 0x0302/0x0607, then 0x0400/0x0800, with out_valid=1 on all three.
  - Then 1 DRAIN cycle with 0/0 and out_valid=0, then done=1 and busy=0 in cycle 5 after start.
- Write while busy:
  - Stimulus: during STREAM, write A row 0 = 0xFFFF; then restart.
  - Required response: the second stream is identical to the first.
- Reset mid-stream:
  - Stimulus: assert reset at step 1, then pulse start with no new writes.
  - Required response: all outputs 0 the cycle after reset and no done pulse. The new stream emits all-zero lanes with out_valid=1 for 3 cycles, then done.
- Back-to-back:
  - Stimulus: hold start=1 continuously.
  - Required response: done pulses every 5 cycles; busy is low only in the done cycles.
- Edge cases:
  - Same-cycle write and start: the written value appears at step 0.
  - wr_row=3 on N=2: write ignored.
  - N=1 build with A=9, B=7: one valid cycle 0x09/0x07, then done next cycle.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand staging buffer for the MAC array: holds one A and one B tile and
// streams them as diagonally skewed vectors, then drains with zeros.

module systolic_feeder_lane #(
    parameter int N        = 16,
    parameter int OP_WIDTH = 8,
    parameter int TW       = 7,
    parameter int LANE     = 0
) (
    input  logic [N*OP_WIDTH-1:0] vec,
    input  logic [TW-1:0]         step,
    input  logic                  en,
    output logic [OP_WIDTH-1:0]   elem
);
    // Lane LANE sees element k of its vector exactly at step k+LANE.
    always_comb begin
        elem = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (step == TW'(k + LANE)) elem = vec[k*OP_WIDTH +: OP_WIDTH];
            end
        end
    end
endmodule

module systolic_feeder #(
    parameter int N        = 16,
    parameter int OP_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic                               wr_sel,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_row,
    input  logic [N*OP_WIDTH-1:0]              wr_data,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               out_valid,
    output logic [N*OP_WIDTH-1:0]              a_column,
    output logic [N*OP_WIDTH-1:0]              b_row
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(3*N) + 1;
    localparam int VW = N*OP_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    localparam logic [TW-1:0] STREAM_LAST = TW'(2*N - 2);
    localparam logic [TW-1:0] DRAIN_LAST  = TW'((N > 1) ? N - 2 : 0);
    localparam bit            SINGLE      = (N == 1);

    logic [1:0]            state_q, state_d;
    logic [TW-1:0]         t_q, t_d;
    logic [N-1:0][VW-1:0]  a_q, a_d, b_q, b_d;
    logic [N-1:0][VW-1:0]  b_col;
    logic                  busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [VW-1:0]         a_col_q, a_col_d, b_row_q, b_row_d;
    logic                  lane_en;

    // Buffer writes only land while idle; a write in the start cycle is
    // visible to step 0 because lanes read the post-write contents.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (wr_en && (state_q == ST_IDLE)) begin
            for (int r = 0; r < N; r++) begin
                if (wr_row == RW'(r)) begin
                    if (wr_sel) b_d[r] = wr_data;
                    else        a_d[r] = wr_data;
                end
            end
        end
    end

    always_comb begin
        b_col = '0;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) begin
                b_col[j][k*OP_WIDTH +: OP_WIDTH] = b_d[k][j*OP_WIDTH +: OP_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    t_d     = '0;
                end
            end
            ST_STREAM: begin
                if (t_q == STREAM_LAST) begin
                    t_d = '0;
                    if (SINGLE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (t_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    t_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Outputs are registered, so the lanes evaluate the step being entered.
    assign lane_en = (state_d == ST_STREAM);
    assign valid_d = lane_en;
    assign busy_d  = (state_d != ST_IDLE);

    for (genvar i = 0; i < N; i++) begin : g_lane
        systolic_feeder_lane #(
            .N(N), .OP_WIDTH(OP_WIDTH), .TW(TW), .LANE(i)
        ) u_a_lane (
            .vec(a_d[i]), .step(t_d), .en(lane_en),
            .elem(a_col_d[i*OP_WIDTH +: OP_WIDTH])
        );
        systolic_feeder_lane #(
            .N(N), .OP_WIDTH(OP_WIDTH), .TW(TW), .LANE(i)
        ) u_b_lane (
            .vec(b_col[i]), .step(t_d), .en(lane_en),
            .elem(b_row_d[i*OP_WIDTH +: OP_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            a_col_q <= '0;
            b_row_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            a_col_q <= a_col_d;
            b_row_q <= b_row_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign a_column  = a_col_q;
    assign b_row     = b_row_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: N=2 main instance plus an N=1 build.

module tb_systolic_feeder;
    localparam int N = 2;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset, wr_en, wr_sel, start;
    logic [0:0]  wr_row;
    logic [15:0] wr_data;
    logic        busy, done, out_valid;
    logic [15:0] a_column, b_row;

    logic        s_wr_en, s_wr_sel, s_start;
    logic [0:0]  s_wr_row;
    logic [7:0]  s_wr_data;
    logic        s_busy, s_done, s_out_valid;
    logic [7:0]  s_a_column, s_b_row;

    int checks = 0;
    int errors = 0;
    logic [7:0] ma[2][2];
    logic [7:0] mb[2][2];

    systolic_feeder #(.N(N), .OP_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_data(wr_data), .start(start), .busy(busy),
        .done(done), .out_valid(out_valid), .a_column(a_column), .b_row(b_row)
    );

    systolic_feeder #(.N(1), .OP_WIDTH(W)) dut1 (
        .clk(clk), .reset(reset), .wr_en(s_wr_en), .wr_sel(s_wr_sel),
        .wr_row(s_wr_row), .wr_data(s_wr_data), .start(s_start), .busy(s_busy),
        .done(s_done), .out_valid(s_out_valid), .a_column(s_a_column), .b_row(s_b_row)
    );

    always #5 clk = ~clk;

    // Reference: cycle c after the start edge -> {a_column, b_row, valid, busy, done}.
    function automatic logic [34:0] expect_at(int c);
        logic [15:0] ea, eb;
        int t, k;
        ea = '0;
        eb = '0;
        if (c >= 1 && c <= 2*N-1) begin
            t = c - 1;
            for (int i = 0; i < N; i++) begin
                k = t - i;
                if (k >= 0 && k < N) begin
                    ea[i*W +: W] = ma[i][k];
                    eb[i*W +: W] = mb[k][i];
                end
            end
            return {ea, eb, 3'b110};
        end
        if (c >= 2*N && c <= 3*N-2) return {32'h0, 3'b010};
        if (c == 3*N-1) return {32'h0, 3'b001};
        return '0;
    endfunction

    function automatic logic [34:0] observed();
        return {a_column, b_row, out_valid, busy, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input logic sel, input int row, input logic [15:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_row = 1'(row); wr_data = data;
        tick();
        wr_en = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (sel) mb[row][c] = data[c*W +: W];
            else     ma[row][c] = data[c*W +: W];
        end
    endtask

    task automatic load_random();
        for (int r = 0; r < N; r++) begin
            write_row(1'b0, r, 16'($urandom));
            write_row(1'b1, r, 16'($urandom));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (observed() !== 35'h0) begin
            errors++;
            $display("FAIL reset_n2 got %h exp %h", observed(), 35'h0);
        end
        checks++;
        if ({s_a_column, s_b_row, s_out_valid, s_busy, s_done} !== 19'h0) begin
            errors++;
            $display("FAIL reset_n1 got %h exp 0", {s_a_column, s_b_row, s_out_valid, s_busy, s_done});
        end
    endtask

    task automatic test_basic();
        write_row(1'b0, 0, 16'h0201);
        write_row(1'b0, 1, 16'h0403);
        write_row(1'b1, 0, 16'h0605);
        write_row(1'b1, 1, 16'h0807);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({a_column, b_row} !== 32'h0001_0005) begin
            errors++;
            $display("FAIL basic_step0 got %h exp %h", {a_column, b_row}, 32'h0001_0005);
        end
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (observed() !== expect_at(c)) begin
                errors++;
                $display("FAIL basic c=%0d got %h exp %h", c, observed(), expect_at(c));
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            load_random();
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 1; c <= 6; c++) begin
                checks++;
                if (observed() !== expect_at(c)) begin
                    errors++;
                    $display("FAIL random n=%0d c=%0d got %h exp %h", n, c, observed(), expect_at(c));
                end
                tick();
            end
        end
    endtask

    task automatic test_write_busy();
        load_random();
        for (int pass = 0; pass < 2; pass++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                checks++;
                if (observed() !== expect_at(c)) begin
                    errors++;
                    $display("FAIL write_busy pass=%0d c=%0d got %h exp %h", pass, c, observed(), expect_at(c));
                end
                wr_en = (pass == 0 && c <= 3);
                wr_sel = 1'b0; wr_row = 1'b0; wr_data = 16'hFFFF;
                tick();
                wr_en = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        load_random();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (observed() !== 35'h0) begin
                errors++;
                $display("FAIL reset_mid idle c=%0d got %h exp %h", c, observed(), 35'h0);
            end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (observed() !== expect_at(c)) begin
                errors++;
                $display("FAIL reset_mid stream c=%0d got %h exp %h", c, observed(), expect_at(c));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        load_random();
        start = 1'b1;
        tick();
        for (int c = 1; c <= 15; c++) begin
            checks++;
            if (observed() !== expect_at(((c - 1) % 5) + 1)) begin
                errors++;
                $display("FAIL back_to_back c=%0d got %h exp %h", c, observed(), expect_at(((c - 1) % 5) + 1));
            end
            if (c == 15) start = 1'b0;
            tick();
        end
        checks++;
        if (observed() !== 35'h0) begin
            errors++;
            $display("FAIL back_to_back stop got %h exp %h", observed(), 35'h0);
        end
    endtask

    task automatic test_same_cycle();
        logic [15:0] d;
        load_random();
        d = 16'($urandom);
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 1'b0; wr_data = d;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        ma[0][0] = d[7:0];
        ma[0][1] = d[15:8];
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (observed() !== expect_at(c)) begin
                errors++;
                $display("FAIL same_cycle c=%0d got %h exp %h", c, observed(), expect_at(c));
            end
            tick();
        end
    endtask

    task automatic test_n1();
        logic [18:0] exp1[3];
        exp1[0] = {8'h09, 8'h07, 3'b110};
        exp1[1] = {16'h0, 3'b001};
        exp1[2] = '0;
        s_wr_en = 1'b1; s_wr_sel = 1'b0; s_wr_row = 1'b0; s_wr_data = 8'h09;
        tick();
        s_wr_sel = 1'b1; s_wr_data = 8'h07;
        tick();
        s_wr_row = 1'b1; s_wr_sel = 1'b0; s_wr_data = 8'hAA;
        tick();
        s_wr_sel = 1'b1; s_wr_data = 8'h55;
        tick();
        s_wr_en = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({s_a_column, s_b_row, s_out_valid, s_busy, s_done} !== exp1[c]) begin
                errors++;
                $display("FAIL n1 c=%0d got %h exp %h", c + 1,
                         {s_a_column, s_b_row, s_out_valid, s_busy, s_done}, exp1[c]);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0;
        s_wr_en = 1'b0; s_wr_sel = 1'b0; s_wr_row = '0; s_wr_data = '0; s_start = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        test_reset();
        test_basic();
        test_random();
        test_write_busy();
        test_reset_mid();
        test_back_to_back();
        test_same_cycle();
        test_n1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
